// File: rtl/lights_pkg.sv
// Shared constants and encodings for the lights frame sender.
package lights_pkg;

    localparam int unsigned CLOCK       = 50000000;
    localparam int unsigned UNIVERSES   = 16;
    localparam int unsigned PIXEL_COUNT = 150;

    typedef enum logic [1:0] {
        BLUE  = 2'd0,
        GREEN = 2'd1,
        RED   = 2'd2
    } colour_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        FETCH = 3'd2,
        SHIFT = 3'd3,
        TRAIL = 3'd4,
        GAP   = 3'd5
    } state_e;

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte shifter: MSB first, sck low then high for CLK_DIV cycles per half-bit.
module spi_byte_shifter #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       sck,
    output logic       mosi,
    output logic       byte_done
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          active_q;
    logic          phase_end;

    assign phase_end = active_q && (div_q == CW'(CLK_DIV - 1));
    // Asserted in the final cycle of the last high phase so a new load can follow seamlessly.
    assign byte_done = phase_end && sck && (bit_q == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= 3'd0;
            shreg_q  <= 8'h00;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else if (load) begin
            active_q <= 1'b1;
            div_q    <= '0;
            bit_q    <= 3'd0;
            shreg_q  <= data;
            sck      <= 1'b0;
            mosi     <= data[7];
        end else if (phase_end) begin
            div_q <= '0;
            if (!sck) begin
                sck <= 1'b1;
            end else begin
                sck <= 1'b0;
                if (bit_q == 3'd7) begin
                    active_q <= 1'b0;
                    mosi     <= 1'b0;
                end else begin
                    bit_q   <= bit_q + 3'd1;
                    shreg_q <= {shreg_q[6:0], 1'b0};
                    mosi    <= shreg_q[6];
                end
            end
        end else if (active_q) begin
            div_q <= div_q + CW'(1);
        end
    end

endmodule

// File: rtl/lights_frame_sender.sv
// Sends one universe frame (header, then B/G/R per pixel) over SPI from a 1-cycle-latency buffer.
// Optional trailing XOR checksum byte when LIGHTS_SENDER_CHECKSUM_EN is defined.
module lights_frame_sender #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned PIXEL_COUNT = lights_pkg::PIXEL_COUNT,
    parameter int unsigned UNIVERSES   = lights_pkg::UNIVERSES,
    parameter int unsigned CS_SETUP    = 8,
    parameter int unsigned CS_GAP      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] universe_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       pix_rd,
    output logic [7:0] pix_addr,
    input  logic [7:0] pix_red,
    input  logic [7:0] pix_green,
    input  logic [7:0] pix_blue,
    output logic       cs,
    output logic       sck,
    output logic       mosi
);

    import lights_pkg::*;

    state_e      state_q;
    colour_e     colour_q;
    logic        hdr_q;
    logic [15:0] cnt_q;
    logic [7:0]  universe_q;
    logic [7:0]  red_q;
    logic [7:0]  green_q;
    logic        load;
    logic [7:0]  load_data;
    logic        byte_done;
    logic        last_pix;
    logic        in_trailer;

`ifdef LIGHTS_SENDER_CHECKSUM_EN
    logic [7:0]  csum_q;
    logic        csum_phase_q;
    assign in_trailer = csum_phase_q;
`else
    assign in_trailer = 1'b0;
`endif

    assign last_pix = (pix_addr == 8'(PIXEL_COUNT - 1));

    always_comb begin
        load      = 1'b0;
        load_data = 8'h00;
        unique case (state_q)
            SETUP: begin
                if (cnt_q == 16'(CS_SETUP - 1)) begin
                    load      = 1'b1;
                    load_data = universe_q;
                end
            end
            FETCH: begin
                if (cnt_q != 16'd0) begin
                    load      = 1'b1;
                    load_data = pix_blue;
                end
            end
            SHIFT: begin
                if (byte_done && !hdr_q && !in_trailer) begin
                    if (colour_q == BLUE) begin
                        load      = 1'b1;
                        load_data = green_q;
                    end else if (colour_q == GREEN) begin
                        load      = 1'b1;
                        load_data = red_q;
                    end
`ifdef LIGHTS_SENDER_CHECKSUM_EN
                    else if (last_pix) begin
                        load      = 1'b1;
                        load_data = csum_q;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            colour_q   <= BLUE;
            hdr_q      <= 1'b0;
            cnt_q      <= 16'd0;
            universe_q <= 8'h00;
            red_q      <= 8'h00;
            green_q    <= 8'h00;
            cs         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            pix_rd     <= 1'b0;
            pix_addr   <= 8'h00;
`ifdef LIGHTS_SENDER_CHECKSUM_EN
            csum_q       <= 8'h00;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            pix_rd <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // The done cycle still counts as busy for start acceptance.
                    if (start && !done) begin
                        if (32'(universe_in) < UNIVERSES) begin
                            universe_q <= universe_in;
                            busy       <= 1'b1;
                            cs         <= 1'b0;
                            pix_addr   <= 8'h00;
                            hdr_q      <= 1'b1;
                            cnt_q      <= 16'd0;
                            state_q    <= SETUP;
`ifdef LIGHTS_SENDER_CHECKSUM_EN
                            csum_q     <= 8'h00;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q == 16'(CS_SETUP - 1)) state_q <= SHIFT;
                    else                            cnt_q   <= cnt_q + 16'd1;
                end
                SHIFT: begin
                    if (byte_done) begin
                        if (hdr_q) begin
                            hdr_q   <= 1'b0;
                            pix_rd  <= 1'b1;
                            cnt_q   <= 16'd0;
                            state_q <= FETCH;
                        end else if (in_trailer) begin
`ifdef LIGHTS_SENDER_CHECKSUM_EN
                            csum_phase_q <= 1'b0;
`endif
                            cnt_q   <= 16'd0;
                            state_q <= TRAIL;
                        end else begin
                            case (colour_q)
                                BLUE: begin
                                    colour_q <= GREEN;
`ifdef LIGHTS_SENDER_CHECKSUM_EN
                                    csum_q   <= csum_q ^ green_q;
`endif
                                end
                                GREEN: begin
                                    colour_q <= RED;
`ifdef LIGHTS_SENDER_CHECKSUM_EN
                                    csum_q   <= csum_q ^ red_q;
`endif
                                end
                                default: begin
                                    if (last_pix) begin
`ifdef LIGHTS_SENDER_CHECKSUM_EN
                                        csum_phase_q <= 1'b1;
`else
                                        cnt_q   <= 16'd0;
                                        state_q <= TRAIL;
`endif
                                    end else begin
                                        pix_addr <= pix_addr + 8'd1;
                                        pix_rd   <= 1'b1;
                                        cnt_q    <= 16'd0;
                                        state_q  <= FETCH;
                                    end
                                end
                            endcase
                        end
                    end
                end
                FETCH: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= 16'd1;
                    end else begin
                        red_q    <= pix_red;
                        green_q  <= pix_green;
                        colour_q <= BLUE;
                        state_q  <= SHIFT;
`ifdef LIGHTS_SENDER_CHECKSUM_EN
                        csum_q   <= csum_q ^ pix_blue;
`endif
                    end
                end
                TRAIL: begin
                    if (cnt_q == 16'(CLK_DIV - 1)) begin
                        cs      <= 1'b1;
                        cnt_q   <= 16'd0;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == 16'(CS_GAP - 1)) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cnt_q   <= 16'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data      (load_data),
        .sck       (sck),
        .mosi      (mosi),
        .byte_done (byte_done)
    );

endmodule

// File: tb/tb_lights_frame_sender.sv
// Directed bench for lights_frame_sender: SPI decode, timing, rejects, ignored starts, reset abort.
module tb_lights_frame_sender;

    localparam int CLK_DIV  = 2;
    localparam int PIX      = 4;
    localparam int CS_SETUP = 8;
    localparam int CS_GAP   = 16;
    localparam int UNIV     = 16;
`ifdef LIGHTS_SENDER_CHECKSUM_EN
    localparam int NBYTES = 1 + 3 * PIX + 1;
`else
    localparam int NBYTES = 1 + 3 * PIX;
`endif
    localparam int CS_LOW = CS_SETUP + NBYTES * 16 * CLK_DIV + 2 * PIX + CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] universe_in = 8'h00;
    logic       busy, done, err, pix_rd, cs, sck, mosi;
    logic [7:0] pix_addr;
    logic [7:0] pix_red = 8'h00, pix_green = 8'h00, pix_blue = 8'h00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lights_frame_sender #(
        .CLK_DIV     (CLK_DIV),
        .PIXEL_COUNT (PIX),
        .UNIVERSES   (UNIV),
        .CS_SETUP    (CS_SETUP),
        .CS_GAP      (CS_GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .universe_in (universe_in),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .pix_rd      (pix_rd),
        .pix_addr    (pix_addr),
        .pix_red     (pix_red),
        .pix_green   (pix_green),
        .pix_blue    (pix_blue),
        .cs          (cs),
        .sck         (sck),
        .mosi        (mosi)
    );

    // Frame buffer with one-cycle read latency.
    always @(posedge clk) begin
        if (pix_rd) begin
            pix_red   <= 8'h10 + pix_addr;
            pix_green <= 8'h20 + pix_addr;
            pix_blue  <= 8'h30 + pix_addr;
        end
    end

    // SPI monitor, sampled mid-cycle.
    logic       mon_clear = 1'b0;
    int         cyc = 0;
    logic       prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    logic [7:0] sh = 8'h00;
    int         bitn = 0;
    logic [7:0] bytes_q[$];
    int         fall_cyc = 0, rise_cyc = 0, first_rise = -1, last_rise = 0;
    bit         have_rise = 1'b0;
    int         r4 = 0, r6 = 0, rother = 0;
    int         low_run = 0, last_low = 0, high_run = 0, last_gap = 0, fall_cnt = 0;
    int         mosi_viol = 0, addr_viol = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
    int         done_gap = -1;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_cs   <= cs;
        prev_sck  <= sck;
        prev_mosi <= mosi;
        if (mon_clear) begin
            bytes_q.delete();
            bitn <= 0; first_rise <= -1; have_rise <= 1'b0;
            r4 <= 0; r6 <= 0; rother <= 0;
            low_run <= 0; last_low <= 0; high_run <= 0; last_gap <= 0; fall_cnt <= 0;
            mosi_viol <= 0; addr_viol <= 0; done_cnt <= 0; err_cnt <= 0; busy_cnt <= 0;
            done_gap <= -1;
        end else begin
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_gap <= cyc - rise_cyc;
            end
            if (err) err_cnt <= err_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            if (pix_rd && pix_addr >= 8'(PIX)) addr_viol <= addr_viol + 1;
            if (sck && mosi !== prev_mosi) mosi_viol <= mosi_viol + 1;
            if (!cs) begin
                high_run <= 0;
                if (prev_cs) begin
                    fall_cnt   <= fall_cnt + 1;
                    fall_cyc   <= cyc;
                    last_gap   <= high_run;
                    low_run    <= 1;
                    have_rise  <= 1'b0;
                    first_rise <= -1;
                    bitn       <= 0;
                end else begin
                    low_run <= low_run + 1;
                end
                if (sck && !prev_sck) begin
                    if (!have_rise) first_rise <= cyc - fall_cyc;
                    else if (cyc - last_rise == 4) r4 <= r4 + 1;
                    else if (cyc - last_rise == 6) r6 <= r6 + 1;
                    else rother <= rother + 1;
                    have_rise <= 1'b1;
                    last_rise <= cyc;
                    if (bitn == 7) begin
                        bytes_q.push_back({sh[6:0], mosi});
                        bitn <= 0;
                    end else begin
                        sh   <= {sh[6:0], mosi};
                        bitn <= bitn + 1;
                    end
                end
            end else begin
                low_run  <= 0;
                high_run <= high_run + 1;
                bitn     <= 0;
                if (!prev_cs) begin
                    last_low <= low_run;
                    rise_cyc <= cyc;
                end
            end
        end
    end

    function automatic logic [7:0] exp_byte(input logic [7:0] uni, input int idx);
        logic [7:0] x;
        int k;
        if (idx == 0) return uni;
        if (idx > 3 * PIX) begin
            x = 8'h00;
            for (int j = 0; j < PIX; j++) x ^= (8'h30 + 8'(j)) ^ (8'h20 + 8'(j)) ^ (8'h10 + 8'(j));
            return x;
        end
        k = (idx - 1) / 3;
        case ((idx - 1) % 3)
            0:       return 8'h30 + 8'(k);
            1:       return 8'h20 + 8'(k);
            default: return 8'h10 + 8'(k);
        endcase
    endfunction

    task automatic clear_mon();
        mon_clear = 1'b1;
        @(negedge clk);
        #1 mon_clear = 1'b0;
    endtask

    task automatic send_start(input logic [7:0] u);
        @(posedge clk);
        #1;
        start = 1'b1;
        universe_in = u;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", cs); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", sck); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (pix_rd !== 1'b0) begin errors++; $display("FAIL reset_pix_rd: got %b want 0", pix_rd); end
        checks++; if (pix_addr !== 8'h00) begin errors++; $display("FAIL reset_pix_addr: got %0d want 0", pix_addr); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL idle_cs: got %b want 1", cs); end
    endtask

    task automatic test_frame();
        bit ok;
        logic [7:0] got;
        clear_mon();
        send_start(8'd3);
        wait_done(3000, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL frame_done_timeout: got no done want done"); end
        checks++;
        if (bytes_q.size() != NBYTES) begin
            errors++; $display("FAIL frame_byte_count: got %0d want %0d", bytes_q.size(), NBYTES);
        end
        for (int i = 0; i < NBYTES; i++) begin
            got = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            checks++;
            if (got !== exp_byte(8'd3, i)) begin
                errors++; $display("FAIL frame_byte%0d: got %02h want %02h", i, got, exp_byte(8'd3, i));
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL frame_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL frame_err: got %0d want 0", err_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_timing();
        checks++;
        if (first_rise != CS_SETUP + CLK_DIV) begin
            errors++; $display("FAIL first_sck_rise: got %0d want %0d", first_rise, CS_SETUP + CLK_DIV);
        end
        checks++;
        if (r4 != NBYTES * 8 - 1 - PIX) begin
            errors++; $display("FAIL sck_period4: got %0d want %0d", r4, NBYTES * 8 - 1 - PIX);
        end
        checks++; if (r6 != PIX) begin errors++; $display("FAIL sck_fetch_gap: got %0d want %0d", r6, PIX); end
        checks++; if (rother != 0) begin errors++; $display("FAIL sck_odd_period: got %0d want 0", rother); end
        checks++; if (mosi_viol != 0) begin errors++; $display("FAIL mosi_stable: got %0d want 0", mosi_viol); end
        checks++; if (last_low != CS_LOW) begin errors++; $display("FAIL cs_low_len: got %0d want %0d", last_low, CS_LOW); end
        checks++; if (done_gap != CS_GAP) begin errors++; $display("FAIL cs_gap_to_done: got %0d want %0d", done_gap, CS_GAP); end
        checks++; if (addr_viol != 0) begin errors++; $display("FAIL pix_addr_range: got %0d want 0", addr_viol); end
    endtask

    task automatic test_bad_universe();
        clear_mon();
        send_start(8'd16);
        repeat (5) @(negedge clk);
        checks++; if (err_cnt != 1) begin errors++; $display("FAIL err_u16: got %0d want 1", err_cnt); end
        checks++; if (fall_cnt != 0) begin errors++; $display("FAIL cs_u16: got %0d falls want 0", fall_cnt); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL busy_u16: got %0d want 0", busy_cnt); end
        send_start(8'hFF);
        repeat (5) @(negedge clk);
        checks++; if (err_cnt != 2) begin errors++; $display("FAIL err_uff: got %0d want 2", err_cnt); end
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL cs_uff: got %b want 1", cs); end
    endtask

    task automatic test_ignore_starts();
        bit ok;
        clear_mon();
        send_start(8'd15);
        repeat (60) @(negedge clk);
        send_start(8'd5);
        send_start(8'd20);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                start = 1'b1;
                universe_in = 8'd5;
                @(posedge clk);
                #1 start = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        repeat (30) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL ign_done_timeout: got no done want done"); end
        checks++; if (fall_cnt != 1) begin errors++; $display("FAIL ign_frames: got %0d want 1", fall_cnt); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL ign_err: got %0d want 0", err_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy: got %b want 0", busy); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
        checks++;
        if (bytes_q.size() < 1 || bytes_q[0] !== 8'h0F) begin
            errors++; $display("FAIL ign_header15: got size %0d want header 0f", bytes_q.size());
        end
        send_start(8'd4);
        wait_done(3000, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL second_done_timeout: got no done want done"); end
        checks++; if (fall_cnt != 2) begin errors++; $display("FAIL second_frames: got %0d want 2", fall_cnt); end
        checks++; if (last_gap < CS_GAP) begin errors++; $display("FAIL cs_gap: got %0d want >=%0d", last_gap, CS_GAP); end
        checks++;
        if (bytes_q.size() != 2 * NBYTES) begin
            errors++; $display("FAIL second_byte_count: got %0d want %0d", bytes_q.size(), 2 * NBYTES);
        end else if (bytes_q[NBYTES] !== 8'h04) begin
            errors++; $display("FAIL second_header: got %02h want 04", bytes_q[NBYTES]);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        logic [7:0] got;
        clear_mon();
        send_start(8'd7);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bytes_q.size() == 4) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL abort_reach_byte5: got %0d bytes want 4", bytes_q.size()); end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL abort_cs: got %b want 1", cs); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL abort_sck: got %b want 0", sck); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        clear_mon();
        send_start(8'd9);
        wait_done(3000, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL rerun_done_timeout: got no done want done"); end
        checks++;
        if (bytes_q.size() != NBYTES) begin
            errors++; $display("FAIL rerun_byte_count: got %0d want %0d", bytes_q.size(), NBYTES);
        end
        for (int i = 0; i < NBYTES; i++) begin
            got = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            checks++;
            if (got !== exp_byte(8'd9, i)) begin
                errors++; $display("FAIL rerun_byte%0d: got %02h want %02h", i, got, exp_byte(8'd9, i));
            end
        end
        checks++; if (last_low != CS_LOW) begin errors++; $display("FAIL rerun_cs_low: got %0d want %0d", last_low, CS_LOW); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_timing();
        test_bad_universe();
        test_ignore_starts();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lights_frame_sender.md
Name: lights_frame_sender

Overview:
SPI controller that transmits one universe frame to the lights FPGA's SPI peripheral port (sender_cs/sck/mosi).
- Frame layout: CS low, one universe header byte, then PIXEL_COUNT pixels of three bytes each in the order blue, green, red, then CS high.
- Pixel bytes are read from an external frame buffer through a synchronous read port with 1-cycle latency.
- The block sits in the host-side controller FPGA, between the frame buffer and the lights data cable.

Parameters:
- CLK_DIV, 4: SCK half-period in clk cycles (>=1); one bit time = 2*CLK_DIV cycles.
- PIXEL_COUNT, 150: pixels per frame (1..256).
- UNIVERSES, 16: number of valid universe indices.
- CS_SETUP, 8: clk cycles between CS falling and the first SCK rising edge.
- CS_GAP, 16: minimum clk cycles CS stays high after a frame.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle frame request; sampled only in IDLE
- universe_in  in  8  universe index, captured on an accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the frame completes
- err  out  1  one-cycle pulse when a start is rejected
- pix_rd  out  1  frame-buffer read strobe
- pix_addr  out  8  pixel index 0..PIXEL_COUNT-1
- pix_red, pix_green, pix_blue  in  8 each  read data, valid the cycle after pix_rd
- cs  out  1  SPI chip select, active low
- sck  out  1  SPI clock, mode 0 (idle low)
- mosi  out  1  SPI data, MSB first

Behaviour:
- Reset values: cs=1, sck=0, mosi=0, busy=0, done=0, err=0, pix_rd=0, pix_addr=0. State = IDLE.
- Reset mid-frame aborts on the next edge: cs returns high immediately, with no partial-byte completion.
- FSM states: IDLE, SETUP, FETCH, SHIFT, TRAIL, GAP.
- IDLE
  - start=1 and universe_in<UNIVERSES: latch the universe, busy=1, cs=0 on the next cycle, go to SETUP.
  - start=1 and universe_in>=UNIVERSES: err pulses 1 cycle, stay IDLE.
  - start while busy is ignored, with no err.
- SETUP: count CS_SETUP cycles, load the header byte, go to SHIFT.
- SHIFT (per byte)
  - mosi presents the bit; sck low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mosi changes only while sck is low, in the cycle sck falls.
  - 8 bits take 16*CLK_DIV cycles.
  - After the last bit: next byte from pixel latch (G or R), FETCH (before each pixel's blue), or TRAIL after the last red.
- FETCH: exactly 2 cycles.
  - Cycle 1: pix_rd=1 with pix_addr=p.
  - Cycle 2: capture R/G/B into the latch and load blue into the shifter.
  - sck stays low throughout.
- TRAIL: hold cs low for CLK_DIV cycles after the final sck falling edge, then cs=1.
- GAP: cs high for CS_GAP cycles. On exit, done=1 for 1 cycle, busy=0 in the same cycle, state=IDLE.
- Pixel index p wraps only via frame end; pix_addr never exceeds PIXEL_COUNT-1.
- Frame length (feature off): CS_SETUP + (1+3*PIXEL_COUNT)*16*CLK_DIV + 2*PIXEL_COUNT + CLK_DIV cycles of cs low.
- A start arriving on the same cycle as done is ignored; the earliest accept is the cycle after done.

Optional Feature:
- Macro: LIGHTS_SENDER_CHECKSUM_EN.
- Defined: an 8-bit XOR of all pixel bytes (header excluded) is shifted as one extra byte after the last red, before TRAIL.
- Undefined: no trailer byte, and the checksum register is absent.

Decomposition:
- Shared package lights_pkg holds:
  - constants CLOCK=50000000, UNIVERSES, PIXEL_COUNT;
  - colour-order enum BLUE=0, GREEN=1, RED=2;
  - the FSM state encoding.
- Natural sub-module: spi_byte_shifter.
  - Does load/shift of 8 bits, sck generation from CLK_DIV, and a byte_done pulse.
  - The top FSM sequences bytes and the frame.

Test Plan (CLK_DIV=2, PIXEL_COUNT=4, CS_SETUP=8, CS_GAP=16 unless stated):
- start with universe_in=3; buffer pixel k={R=0x10+k, G=0x20+k, B=0x30+k} -> bench SPI model decodes 0x03,0x30,0x20,0x10,0x31,0x21,0x11,...,0x33,0x23,0x13. Exactly 13 bytes; done pulses once.
- Measure timing on the same frame -> first sck rise 8+2 cycles after cs falls; sck period 4 cycles; mosi stable at every sck rise; cs low for exactly 8+13*32+8+2 cycles.
- start with universe_in=16 -> err 1 cycle, cs stays 1, busy stays 0.
- start pulses while busy and on the done cycle -> ignored; second frame begins only after a start issued post-done; cs high between frames for >=16 cycles.
- Assert rst during byte 5 -> next cycle cs=1, sck=0, busy=0; a new start then produces a full, correct frame.
- With LIGHTS_SENDER_CHECKSUM_EN and the data above -> 14th byte equals the XOR of the 12 pixel bytes; without the macro -> 13 bytes only.
